// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl
//   Bit-serial add/subtract controller. One full_adder_1bit cell is reused for
//   every bit of a WIDTH-bit operation, LSB first, one bit per clock.
//   Results are presented on a VALID/ACK handshake.
//
//   Ports
//     clk_i      rising-edge clock
//     rst_n_i    synchronous active-low reset
//     start_i    request, accepted only while ready_o=1
//     a_i, b_i   operands, captured on accept
//     cin_i      carry-in for add (ignored for subtract)
//     sub_i      1: a-b, 0: a+b+cin; captured on accept
//     ack_i      consumer takes the result while valid_o=1
//     ready_o    idle, can accept a request
//     busy_o     serial operation in progress
//     valid_o    sum_o/cout_o/ovf_o hold a result
//     sum_o      result, modulo 2^WIDTH
//     cout_o     carry out of the MSB (for subtract: 1 = no borrow)
//     ovf_o      signed overflow
//
//   state | meaning
//   ------+-----------------------------------------------
//   IDLE  | waiting for start_i, ready_o=1
//   RUN   | one result bit per clock, WIDTH clocks
//   DONE  | result valid, held until ack_i

module full_adder_1bit (
   input  logic a_i,
   input  logic b_i,
   input  logic c_i,
   output logic s_o,
   output logic co_o
);
   assign s_o  = a_i ^ b_i ^ c_i;
   assign co_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module serial_adder_ctrl #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             start_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             cin_i,
   input  logic             sub_i,
   input  logic             ack_i,
   output logic             ready_o,
   output logic             busy_o,
   output logic             valid_o,
   output logic [WIDTH-1:0] sum_o,
   output logic             cout_o,
   output logic             ovf_o
);
   localparam int unsigned CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               carry_q;
   logic [WIDTH-1:0]   a_sh_q;
   logic [WIDTH-1:0]   b_sh_q;
   // Holds the WIDTH-1 bits already computed; the MSB comes straight
   // from the adder on the final edge.
   logic [WIDTH-2:0]   res_q;
   logic [WIDTH-1:0]   sum_q;
   logic               cout_q;
   logic               ovf_q;

   logic               fa_sum;
   logic               fa_cout;
   logic [WIDTH-1:0]   sum_d;
   logic [WIDTH-2:0]   res_d;

   full_adder_1bit u_fa (
      .a_i  (a_sh_q[0]),
      .b_i  (b_sh_q[0]),
      .c_i  (carry_q),
      .s_o  (fa_sum),
      .co_o (fa_cout)
   );

   // New bit enters at the top, everything moves one place toward the LSB.
   assign sum_d = {fa_sum, res_q};
   assign res_d = sum_d[WIDTH-1:1];

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         res_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  a_sh_q  <= a_i;
                  // Subtract as a + ~b + 1; cin is not used then.
                  b_sh_q  <= sub_i ? ~b_i : b_i;
                  carry_q <= sub_i ? 1'b1 : cin_i;
                  cnt_q   <= '0;
                  state_q <= S_RUN;
               end
            end
            S_RUN: begin
               a_sh_q  <= a_sh_q >> 1;
               b_sh_q  <= b_sh_q >> 1;
               res_q   <= res_d;
               carry_q <= fa_cout;
               if (cnt_q == CNT_LAST) begin
                  // carry_q is the carry into the MSB on this bit.
                  sum_q   <= sum_d;
                  cout_q  <= fa_cout;
                  ovf_q   <= carry_q ^ fa_cout;
                  state_q <= S_DONE;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            S_DONE: begin
               if (ack_i) begin
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign ready_o = (state_q == S_IDLE);
   assign busy_o  = (state_q == S_RUN);
   assign valid_o = (state_q == S_DONE);
   assign sum_o   = sum_q;
   assign cout_o  = cout_q;
   assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl at WIDTH=8. Expected results are queued when an
// operation is accepted and popped when valid_o is seen.

module tb_serial_adder_ctrl;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a_in;
   logic [W-1:0] b_in;
   logic         cin;
   logic         sub;
   logic         ack;
   logic         ready;
   logic         busy;
   logic         valid;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;

   int checks   = 0;
   int failures = 0;

   // {sum, cout, ovf}
   logic [W+1:0] sb[$];

   always #5 clk = ~clk;

   serial_adder_ctrl #(.WIDTH(W)) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .start_i (start),
      .a_i     (a_in),
      .b_i     (b_in),
      .cin_i   (cin),
      .sub_i   (sub),
      .ack_i   (ack),
      .ready_o (ready),
      .busy_o  (busy),
      .valid_o (valid),
      .sum_o   (sum),
      .cout_o  (cout),
      .ovf_o   (ovf)
   );

   function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic c, input logic s);
      logic [W-1:0] bb;
      logic [W:0]   t;
      logic         ov;
      bb = s ? ~b : b;
      t  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (s ? 1'b1 : c)};
      ov = (a[W-1] == bb[W-1]) && (t[W-1] != a[W-1]);
      return {t[W-1:0], t[W], ov};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic c, input logic s);
      a_in  = a;
      b_in  = b;
      cin   = c;
      sub   = s;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_valid(input int max, output bit ok);
      ok = 1'b0;
      for (int i = 0; i <= max; i++) begin
         if (valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b1;
      a_in  = 8'hFF;
      b_in  = 8'hFF;
      tick();
      tick();
      start = 1'b0;
      checks++;
      if ({ready, busy, valid, sum, cout, ovf} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL reset_state: got rdy=%b busy=%b vld=%b sum=%h cout=%b ovf=%b, want rdy=1 busy=0 vld=0 sum=00 cout=0 ovf=0",
                  ready, busy, valid, sum, cout, ovf);
      end
      rst_n = 1'b1;
      tick();
      checks++;
      if (ready !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_release: got rdy=%b busy=%b, want rdy=1 busy=0", ready, busy);
      end
   endtask

   task automatic test_basic_add();
      logic [W+1:0] exp;
      sb.push_back({8'h3F, 1'b0, 1'b0});
      start_op(8'h35, 8'h0A, 1'b0, 1'b0);
      for (int i = 0; i < W; i++) begin
         checks++;
         if (busy !== 1'b1 || valid !== 1'b0) begin
            failures++;
            $display("FAIL t1_busy cycle %0d: got busy=%b vld=%b, want busy=1 vld=0", i, busy, valid);
         end
         tick();
      end
      checks++;
      if (valid !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL t1_latency: got vld=%b busy=%b after %0d edges, want vld=1 busy=0", valid, busy, W);
      end
      exp = sb.pop_front();
      checks++;
      if ({sum, cout, ovf} !== exp) begin
         failures++;
         $display("FAIL t1_result: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                  sum, cout, ovf, exp[W+1:2], exp[1], exp[0]);
      end
      ack = 1'b1;
      tick();
      ack = 1'b0;
      checks++;
      if (ready !== 1'b1 || valid !== 1'b0) begin
         failures++;
         $display("FAIL t1_ack: got rdy=%b vld=%b, want rdy=1 vld=0", ready, valid);
      end
   endtask

   // Table entry: {a, b, cin, sub, sum, cout, ovf}
   task automatic test_table(input string name, input logic [2*W+2+W+1:0] tbl[$]);
      logic [W+1:0] exp;
      logic [2*W+2+W+1:0] e;
      bit ok;
      foreach (tbl[k]) begin
         e = tbl[k];
         sb.push_back(e[W+1:0]);
         start_op(e[2*W+2+W+1 -: W], e[W+2+W+1 -: W], e[W+3], e[W+2]);
         wait_valid(W + 2, ok);
         checks++;
         if (!ok) begin
            failures++;
            $display("FAIL %s_timeout entry %0d: got vld=%b, want vld=1", name, k, valid);
         end
         exp = sb.pop_front();
         checks++;
         if ({sum, cout, ovf} !== exp) begin
            failures++;
            $display("FAIL %s_result entry %0d: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                     name, k, sum, cout, ovf, exp[W+1:2], exp[1], exp[0]);
         end
         ack = 1'b1;
         tick();
         ack = 1'b0;
      end
   endtask

   task automatic test_edges();
      logic [2*W+2+W+1:0] tbl[$];
      tbl = '{ {8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0},
               {8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1} };
      test_table("t2", tbl);
   endtask

   task automatic test_sub();
      logic [2*W+2+W+1:0] tbl[$];
      tbl = '{ {8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0},
               {8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1},
               {8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0},
               {8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1} };
      test_table("t3", tbl);
   endtask

   task automatic test_ignored_inputs();
      logic [W+1:0] exp;
      bit ok;
      sb.push_back({8'h46, 1'b0, 1'b0});
      start_op(8'h12, 8'h34, 1'b0, 1'b0);
      for (int i = 0; i < W; i++) begin
         a_in  = W'($urandom);
         b_in  = W'($urandom);
         sub   = 1'($urandom);
         cin   = 1'($urandom);
         start = (i % 2 == 0);
         tick();
      end
      start = 1'b0;
      wait_valid(4, ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL t4_timeout: got vld=%b, want vld=1", valid);
      end
      exp = sb.pop_front();
      checks++;
      if ({sum, cout, ovf} !== exp) begin
         failures++;
         $display("FAIL t4_result: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                  sum, cout, ovf, exp[W+1:2], exp[1], exp[0]);
      end
      for (int i = 0; i < 20; i++) begin
         start = 1'b1;
         a_in  = W'($urandom);
         b_in  = W'($urandom);
         tick();
         checks++;
         if (valid !== 1'b1 || busy !== 1'b0 || {sum, cout, ovf} !== exp) begin
            failures++;
            $display("FAIL t4_hold cycle %0d: got vld=%b busy=%b sum=%h cout=%b ovf=%b, want vld=1 busy=0 sum=%h cout=%b ovf=%b",
                     i, valid, busy, sum, cout, ovf, exp[W+1:2], exp[1], exp[0]);
         end
      end
      ack = 1'b1;
      tick();
      ack   = 1'b0;
      start = 1'b0;
      checks++;
      if (ready !== 1'b1 || busy !== 1'b0 || valid !== 1'b0) begin
         failures++;
         $display("FAIL t4_ack_with_start: got rdy=%b busy=%b vld=%b, want rdy=1 busy=0 vld=0", ready, busy, valid);
      end
      checks++;
      if ({sum, cout, ovf} !== exp) begin
         failures++;
         $display("FAIL t4_retain: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                  sum, cout, ovf, exp[W+1:2], exp[1], exp[0]);
      end
   endtask

   task automatic test_reset_mid_run();
      logic [W+1:0] exp;
      bit ok;
      sb.delete();
      start_op(8'h55, 8'h11, 1'b0, 1'b0);
      tick();
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      checks++;
      if ({ready, busy, valid, sum, cout, ovf} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL t5_reset: got rdy=%b busy=%b vld=%b sum=%h cout=%b ovf=%b, want rdy=1 busy=0 vld=0 sum=00 cout=0 ovf=0",
                  ready, busy, valid, sum, cout, ovf);
      end
      tick();
      checks++;
      if (ready !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL t5_no_resume: got rdy=%b busy=%b, want rdy=1 busy=0", ready, busy);
      end
      sb.push_back({8'h30, 1'b0, 1'b0});
      start_op(8'h10, 8'h20, 1'b0, 1'b0);
      wait_valid(W + 2, ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL t5_timeout: got vld=%b, want vld=1", valid);
      end
      exp = sb.pop_front();
      checks++;
      if ({sum, cout, ovf} !== exp) begin
         failures++;
         $display("FAIL t5_result: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                  sum, cout, ovf, exp[W+1:2], exp[1], exp[0]);
      end
      ack = 1'b1;
      tick();
      ack = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [W+1:0] exp;
      logic [W-1:0] a, b;
      logic         c, s;
      bit ok;
      int nfail;
      nfail = 0;
      ack = 1'b1;
      for (int n = 0; n < 1000; n++) begin
         a = W'($urandom);
         b = W'($urandom);
         c = 1'($urandom);
         s = 1'($urandom);
         sb.push_back(model(a, b, c, s));
         start_op(a, b, c, s);
         wait_valid(W + 2, ok);
         checks++;
         if (!ok) begin
            failures++;
            $display("FAIL t6_timeout op %0d: got vld=%b, want vld=1", n, valid);
         end
         exp = sb.pop_front();
         checks++;
         if ({sum, cout, ovf} !== exp) begin
            failures++;
            nfail++;
            if (nfail < 10)
               $display("FAIL t6_result op %0d a=%h b=%h cin=%b sub=%b: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                        n, a, b, c, s, sum, cout, ovf, exp[W+1:2], exp[1], exp[0]);
         end
         tick();
         checks++;
         if (valid !== 1'b0 || ready !== 1'b1) begin
            failures++;
            $display("FAIL t6_pulse op %0d: got vld=%b rdy=%b, want vld=0 rdy=1", n, valid, ready);
         end
      end
      ack = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      a_in  = '0;
      b_in  = '0;
      cin   = 1'b0;
      sub   = 1'b0;
      ack   = 1'b0;
      test_reset();
      test_basic_add();
      test_edges();
      test_sub();
      test_ignored_inputs();
      test_reset_mid_run();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
